// File: rtl/ui_math_pkg.sv
// ui_math_pkg
// Shared constants and helpers for the unsigned math-core wrappers.
//   UI_DEFAULT_N : default operand width in bits
//   clog2()      : ceiling log2, usable in parameter expressions
//   hs_fire()    : valid/ready handshake completes this cycle
package ui_math_pkg;

  localparam int UI_DEFAULT_N = 64;

  // Ceiling log2 with a fixed loop bound so it elaborates as a constant.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/ui_fifo_sync.sv
// ui_fifo_sync
// Small synchronous FIFO with an occupancy counter.
// Parameters: N (data width), DEPTH (entries, power of two, 2..64).
// Ports:
//   clk, rstn : rising-edge clock, synchronous active-low reset
//   clr       : synchronous clear (empties the FIFO)
//   push, din : write request and data; ignored while full
//   pop, dout : read request; dout shows the head entry
//   full, empty, level : status derived from the registered counter
import ui_math_pkg::*;

module ui_fifo_sync #(
  parameter int N     = UI_DEFAULT_N,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok_s, pop_ok_s;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == (AW+1)'(0));
  assign level     = cnt_q;
  assign dout      = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even if it pops in the same cycle.
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      cnt_d    = (AW+1)'(0);
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; storage is zeroed on reset so dout is never X.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      cnt_q    <= (AW+1)'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ui_sub_operand_join.sv
// ui_sub_operand_join
// Pairs two independent operand streams (minuend A, subtrahend B) in strict
// arrival order and presents each pair from a registered valid/ready output.
// Parameters: N (operand width), DEPTH (entries per operand FIFO).
// Ports:
//   clk, rstn          : rising-edge clock, synchronous active-low reset
//   flush              : synchronous clear of both FIFOs and the output
//   a_data/a_valid/a_ready, b_data/b_valid/b_ready : input streams
//   out_a/out_b/out_valid/out_ready                : paired output
// Optional build macro UI_SUB_JOIN_STATS_EN adds pair_cnt, a_level, b_level.
import ui_math_pkg::*;

module ui_sub_operand_join #(
  parameter int N     = UI_DEFAULT_N,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic [N-1:0]  a_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [N-1:0]  b_data,
  input  logic          b_valid,
  output logic          b_ready,
  output logic [N-1:0]  out_a,
  output logic [N-1:0]  out_b,
  output logic          out_valid,
`ifdef UI_SUB_JOIN_STATS_EN
  output logic [31:0]   pair_cnt,
  output logic [AW:0]   a_level,
  output logic [AW:0]   b_level,
`endif
  input  logic          out_ready
);

  logic [N-1:0] a_head_s, b_head_s;
  logic         a_full_s, a_empty_s, b_full_s, b_empty_s;
  logic [AW:0]  a_level_s, b_level_s;
  logic         load_s, out_fire_s;

  logic [N-1:0] out_a_q, out_a_d;
  logic [N-1:0] out_b_q, out_b_d;
  logic         out_valid_q, out_valid_d;

  // Ready depends only on registered FIFO state, never on out_ready.
  assign a_ready    = ~a_full_s;
  assign b_ready    = ~b_full_s;
  assign out_fire_s = hs_fire(out_valid_q, out_ready);
  // The output register takes a new pair when it is empty or being drained.
  assign load_s     = ~a_empty_s & ~b_empty_s & (~out_valid_q | out_ready);

  ui_fifo_sync #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush),
    .push  (hs_fire(a_valid, a_ready)),
    .pop   (load_s),
    .din   (a_data),
    .dout  (a_head_s),
    .full  (a_full_s),
    .empty (a_empty_s),
    .level (a_level_s)
  );

  ui_fifo_sync #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush),
    .push  (hs_fire(b_valid, b_ready)),
    .pop   (load_s),
    .din   (b_data),
    .dout  (b_head_s),
    .full  (b_full_s),
    .empty (b_empty_s),
    .level (b_level_s)
  );

  // Output register next-state: flush, load a pair, drain, or hold.
  always_comb begin
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_a_d     = '0;
      out_b_d     = '0;
      out_valid_d = 1'b0;
    end else if (load_s) begin
      out_a_d     = a_head_s;
      out_b_d     = b_head_s;
      out_valid_d = 1'b1;
    end else if (out_fire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_valid = out_valid_q;

`ifdef UI_SUB_JOIN_STATS_EN
  logic [31:0] pair_cnt_q, pair_cnt_d;

  // Pair counter next-state; wraps naturally at 2^32.
  always_comb begin
    pair_cnt_d = pair_cnt_q;
    if (flush) begin
      pair_cnt_d = 32'd0;
    end else if (out_fire_s) begin
      pair_cnt_d = pair_cnt_q + 32'd1;
    end else begin
      pair_cnt_d = pair_cnt_q;
    end
  end

  // Pair counter register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pair_cnt_q <= 32'd0;
    end else begin
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign pair_cnt = pair_cnt_q;
  assign a_level  = a_level_s;
  assign b_level  = b_level_s;
`else
  // Occupancy is only exported in the stats build.
  logic level_unused_s;
  assign level_unused_s = ^{a_level_s, b_level_s};
`endif

endmodule

// File: tb/tb_ui_sub_operand_join.sv
// tb_ui_sub_operand_join
// Self-checking bench: directed scenarios with literal expectations plus a
// long randomized run, all compared every cycle against a queue-based model.
module tb_ui_sub_operand_join;

  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rstn, flush;
  logic [N-1:0] a_data, b_data;
  logic         a_valid, b_valid, out_ready;
  logic         a_ready, b_ready, out_valid;
  logic [N-1:0] out_a, out_b;
`ifdef UI_SUB_JOIN_STATS_EN
  logic [31:0]  pair_cnt;
  logic [2:0]   a_level, b_level;
`endif

  int total = 0;
  int bad   = 0;

  ui_sub_operand_join #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_valid (out_valid),
`ifdef UI_SUB_JOIN_STATS_EN
    .pair_cnt  (pair_cnt),
    .a_level   (a_level),
    .b_level   (b_level),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: two queues plus one output slot.
  logic [N-1:0] qa[$], qb[$];
  logic         m_ov = 1'b0;
  logic [N-1:0] m_oa = '0, m_ob = '0;
  int unsigned  m_cnt = 0;
  bit           m_fa, m_fb, m_ld;

  always @(posedge clk) begin
    if (!rstn || flush) begin
      qa.delete(); qb.delete();
      m_ov = 1'b0; m_oa = '0; m_ob = '0; m_cnt = 0;
    end else begin
      m_fa = a_valid && (qa.size() < DEPTH);
      m_fb = b_valid && (qb.size() < DEPTH);
      if (m_ov && out_ready) m_cnt++;
      m_ld = (qa.size() > 0) && (qb.size() > 0) && (!m_ov || out_ready);
      if (m_ld) begin
        m_oa = qa.pop_front();
        m_ob = qb.pop_front();
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (m_fa) qa.push_back(a_data);
      if (m_fb) qb.push_back(b_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_ready", {63'd0, a_ready}, {63'd0, qa.size() < DEPTH});
      check("b_ready", {63'd0, b_ready}, {63'd0, qb.size() < DEPTH});
      check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
      if (m_ov) begin
        check("out_a", out_a, m_oa);
        check("out_b", out_b, m_ob);
      end
`ifdef UI_SUB_JOIN_STATS_EN
      check("pair_cnt", {32'd0, pair_cnt}, {32'd0, m_cnt});
      check("a_level", {61'd0, a_level}, 64'(qa.size()));
      check("b_level", {61'd0, b_level}, 64'(qb.size()));
`endif
    end
  end

  // Records pairs handed downstream, then advances one cycle.
  logic [N-1:0] got_a[$], got_b[$];
  task automatic tick();
    if (out_valid && out_ready) begin
      got_a.push_back(out_a);
      got_b.push_back(out_b);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
    a_data = '0; b_data = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  int na, nb, acc, cnt;

  initial begin
    rstn = 1'b0; out_ready = 1'b1;
    idle_inputs();
    tick(); tick();
    rstn = 1'b1;
    chk_en = 1'b1;
    // Reset state
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_a", out_a, 64'd0);
    check("rst_out_b", out_b, 64'd0);
    check("rst_a_ready", {63'd0, a_ready}, 64'd1);
    check("rst_b_ready", {63'd0, b_ready}, 64'd1);

    // Single pair latency: visible two edges after acceptance, for one cycle.
    a_valid = 1'b1; a_data = 64'd10; b_valid = 1'b1; b_data = 64'd3;
    tick();
    idle_inputs();
    check("lat_t1_valid", {63'd0, out_valid}, 64'd0);
    tick();
    check("lat_t2_valid", {63'd0, out_valid}, 64'd1);
    check("lat_t2_a", out_a, 64'd10);
    check("lat_t2_b", out_b, 64'd3);
    tick();
    check("lat_t3_valid", {63'd0, out_valid}, 64'd0);

    // A streams alone until full, then B catches up.
    got_a.delete(); got_b.delete();
    na = 1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_data = 64'(na);
      if (a_ready) begin na++; acc++; end
      tick();
    end
    check("fill_accepts", 64'(acc), 64'(DEPTH));
    check("fill_a_ready", {63'd0, a_ready}, 64'd0);
    nb = 101;
    for (int i = 0; i < 60 && got_a.size() < 8; i++) begin
      a_valid = (na <= 8); a_data = 64'(na);
      b_valid = (nb <= 108); b_data = 64'(nb);
      if (a_valid && a_ready) na++;
      if (b_valid && b_ready) nb++;
      tick();
    end
    idle_inputs();
    check("imb_count", 64'(got_a.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_a.size(); i++) begin
      check("imb_a", got_a[i], 64'(i + 1));
      check("imb_b", got_b[i], 64'(i + 101));
    end

    // Sustained throughput with all-ones operands.
    a_valid = 1'b1; b_valid = 1'b1; a_data = '1; b_data = '1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i >= 2 && out_valid) cnt++;
    end
    check("thru_cycles", 64'(cnt), 64'd10);
    check("thru_a", out_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("thru_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // Backpressure: (7,2) held while both FIFOs fill.
    do_flush();
    got_a.delete(); got_b.delete();
    a_valid = 1'b1; a_data = 64'd7; b_valid = 1'b1; b_data = 64'd2;
    tick();
    out_ready = 1'b0;
    na = 8; nb = 3;
    for (int i = 0; i < 6; i++) begin
      a_data = 64'(na); b_data = 64'(nb);
      if (a_ready) na++;
      if (b_ready) nb++;
      tick();
      if (i >= 1) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_a", out_a, 64'd7);
        check("hold_b", out_b, 64'd2);
      end
    end
    check("bp_a_ready", {63'd0, a_ready}, 64'd0);
    check("bp_b_ready", {63'd0, b_ready}, 64'd0);
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("bp_count", 64'(got_a.size()), 64'd5);
    for (int i = 0; i < 5 && i < got_a.size(); i++) begin
      check("bp_a", got_a[i], 64'(7 + i));
      check("bp_b", got_b[i], 64'(2 + i));
    end

    // Flush with 3 A and 1 B buffered behind a held pair.
    out_ready = 1'b0;
    a_valid = 1'b1; a_data = 64'd50; b_valid = 1'b1; b_data = 64'd60;
    tick();
    b_valid = 1'b0; a_data = 64'd51;
    tick();
    b_valid = 1'b1; b_data = 64'd61; a_data = 64'd52;
    tick();
    b_valid = 1'b0; a_data = 64'd53;
    tick();
    check("pre_flush_valid", {63'd0, out_valid}, 64'd1);
    a_valid = 1'b1; b_valid = 1'b1; a_data = 64'd99; b_data = 64'd98;
    do_flush();
    idle_inputs();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_a_ready", {63'd0, a_ready}, 64'd1);
    check("flush_b_ready", {63'd0, b_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("flush_no_stale", {63'd0, out_valid}, 64'd0);
    end

`ifdef UI_SUB_JOIN_STATS_EN
    // Pair counter: five pairs, then cleared by reset.
    do_flush();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 64'd5; b_data = 64'd1;
    for (int i = 0; i < 5; i++) tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    check("stats_cnt5", {32'd0, pair_cnt}, 64'd5);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("stats_rst_cnt", {32'd0, pair_cnt}, 64'd0);
    check("stats_rst_valid", {63'd0, out_valid}, 64'd0);
`endif

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      a_data    = {$urandom, $urandom};
      b_data    = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rstn      = ($urandom_range(0, 299) != 0);
      tick();
    end
    idle_inputs();
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("final_drained", {63'd0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
